// File: rtl/eth_frame_tx.sv
// RMII Ethernet frame transmitter: preamble, SFD, 60 latched bytes, optional CRC-32 FCS, then IPG.
// Define ETH_TX_FCS_EN to compile in the FCS state and CRC-32 generator.
module eth_frame_tx #(
    parameter int IPG_BYTES = 12
) (
    input  logic         eth_clk,
    input  logic         rst_in,
    input  logic         send_packet,
    input  logic [479:0] eth_packet,
    output logic         busy,
    output logic         tx_done,
    output logic [7:0]   drop_count,
    output logic         eth_txen,
    output logic [1:0]   eth_txd
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_DATA     = 3'd3,
        ST_FCS      = 3'd4,
        ST_IPG      = 3'd5
    } state_e;

    localparam logic [7:0] IPG_LAST = 8'(IPG_BYTES - 1);

    state_e       state_q, state_d;
    logic [1:0]   dibit_q, dibit_d;
    logic [7:0]   byte_q, byte_d;
    logic [479:0] shreg_q, shreg_d;
    logic         busy_q, busy_d;
    logic         tx_done_q, tx_done_d;
    logic [7:0]   drop_count_q, drop_count_d;
    logic         eth_txen_q, eth_txen_d;
    logic [1:0]   eth_txd_q, eth_txd_d;
    logic [7:0]   last_byte_s;
    logic         byte_end_s;
    logic         state_end_s;
    state_e       state_after_s;

`ifdef ETH_TX_FCS_EN
    logic [31:0]  crc_q, crc_d;

    // Reflected CRC-32 advanced by one dibit, bit 0 entering first.
    function automatic logic [31:0] crc32_dibit(input logic [31:0] crc, input logic [1:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 2; i++) begin
            if ((c[0] ^ d[i]) == 1'b1) begin
                c = (c >> 1) ^ 32'hEDB8_8320;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction
`endif

    // Bytes leave the wire least-significant dibit first.
    function automatic logic [1:0] dibit_of(input logic [7:0] b, input logic [1:0] idx);
        logic [1:0] d;
        case (idx)
            2'd0:    d = b[1:0];
            2'd1:    d = b[3:2];
            2'd2:    d = b[5:4];
            2'd3:    d = b[7:6];
            default: d = 2'b00;
        endcase
        return d;
    endfunction

    // Per-state byte length and successor state.
    always_comb begin
        last_byte_s   = 8'd0;
        state_after_s = ST_IDLE;
        case (state_q)
            ST_PREAMBLE: begin
                last_byte_s   = 8'd6;
                state_after_s = ST_SFD;
            end
            ST_SFD: begin
                last_byte_s   = 8'd0;
                state_after_s = ST_DATA;
            end
            ST_DATA: begin
                last_byte_s   = 8'd59;
`ifdef ETH_TX_FCS_EN
                state_after_s = ST_FCS;
`else
                state_after_s = ST_IPG;
`endif
            end
            ST_FCS: begin
                last_byte_s   = 8'd3;
                state_after_s = ST_IPG;
            end
            ST_IPG: begin
                last_byte_s   = IPG_LAST;
                state_after_s = ST_IDLE;
            end
            default: begin
                last_byte_s   = 8'd0;
                state_after_s = ST_IDLE;
            end
        endcase
        byte_end_s  = (dibit_q == 2'd3);
        state_end_s = byte_end_s && (byte_q == last_byte_s);
    end

    // Next-state, counters, frame shift register and CRC.
    always_comb begin
        state_d = state_q;
        dibit_d = dibit_q;
        byte_d  = byte_q;
        shreg_d = shreg_q;
`ifdef ETH_TX_FCS_EN
        crc_d   = crc_q;
`endif
        if (state_q == ST_IDLE) begin
            if (send_packet && !busy_q) begin
                state_d = ST_PREAMBLE;
                dibit_d = 2'd0;
                byte_d  = 8'd0;
                shreg_d = eth_packet;
`ifdef ETH_TX_FCS_EN
                crc_d   = 32'hFFFF_FFFF;
`endif
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            if (state_end_s) begin
                state_d = state_after_s;
                dibit_d = 2'd0;
                byte_d  = 8'd0;
            end else if (byte_end_s) begin
                dibit_d = 2'd0;
                byte_d  = byte_q + 8'd1;
            end else begin
                dibit_d = dibit_q + 2'd1;
            end
            if ((state_q == ST_DATA) && byte_end_s) begin
                shreg_d = {shreg_q[471:0], 8'h00};
            end else begin
                shreg_d = shreg_q;
            end
`ifdef ETH_TX_FCS_EN
            // The FCS is drained from the low end of the register two bits per clock.
            if (state_q == ST_DATA) begin
                crc_d = crc32_dibit(crc_q, dibit_of(shreg_q[479:472], dibit_q));
            end else if (state_q == ST_FCS) begin
                crc_d = {2'b00, crc_q[31:2]};
            end else begin
                crc_d = crc_q;
            end
`endif
        end
    end

    // Output values for the coming cycle, derived from the next state so the pins are flopped.
    always_comb begin
        eth_txen_d = 1'b0;
        eth_txd_d  = 2'b00;
        busy_d     = (state_d != ST_IDLE);
        tx_done_d  = (state_d == ST_IPG) && (state_q != ST_IPG);
        case (state_d)
            ST_PREAMBLE: begin
                eth_txen_d = 1'b1;
                eth_txd_d  = 2'b01;
            end
            ST_SFD: begin
                eth_txen_d = 1'b1;
                eth_txd_d  = (dibit_d == 2'd3) ? 2'b11 : 2'b01;
            end
            ST_DATA: begin
                eth_txen_d = 1'b1;
                eth_txd_d  = dibit_of(shreg_d[479:472], dibit_d);
            end
`ifdef ETH_TX_FCS_EN
            ST_FCS: begin
                eth_txen_d = 1'b1;
                eth_txd_d  = ~crc_d[1:0];
            end
`endif
            default: begin
                eth_txen_d = 1'b0;
                eth_txd_d  = 2'b00;
            end
        endcase
        if (send_packet && busy_q && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end else begin
            drop_count_d = drop_count_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge eth_clk) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            dibit_q      <= 2'd0;
            byte_q       <= 8'd0;
            shreg_q      <= 480'd0;
            busy_q       <= 1'b0;
            tx_done_q    <= 1'b0;
            drop_count_q <= 8'd0;
            eth_txen_q   <= 1'b0;
            eth_txd_q    <= 2'b00;
`ifdef ETH_TX_FCS_EN
            crc_q        <= 32'hFFFF_FFFF;
`endif
        end else begin
            state_q      <= state_d;
            dibit_q      <= dibit_d;
            byte_q       <= byte_d;
            shreg_q      <= shreg_d;
            busy_q       <= busy_d;
            tx_done_q    <= tx_done_d;
            drop_count_q <= drop_count_d;
            eth_txen_q   <= eth_txen_d;
            eth_txd_q    <= eth_txd_d;
`ifdef ETH_TX_FCS_EN
            crc_q        <= crc_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign tx_done    = tx_done_q;
    assign drop_count = drop_count_q;
    assign eth_txen   = eth_txen_q;
    assign eth_txd    = eth_txd_q;

endmodule

// File: tb/tb_eth_frame_tx.sv
// Self-checking bench for eth_frame_tx: frame table, randomized frames against a byte-level model,
// mid-frame reset, drop saturation and a 1-byte-IPG instance for back-to-back timing.
module tb_eth_frame_tx;

`ifdef ETH_TX_FCS_EN
    localparam int FCS_BYTES = 4;
`else
    localparam int FCS_BYTES = 0;
`endif
    localparam int IPG        = 12;
    localparam int WIRE_BYTES = 8 + 60 + FCS_BYTES;
    localparam int TXEN_LEN   = WIRE_BYTES * 4;
    localparam int BUSY_LEN   = TXEN_LEN + IPG * 4;

    logic         eth_clk = 1'b0;
    logic         rst_in;
    logic         send_packet;
    logic [479:0] eth_packet;
    logic         busy, tx_done, eth_txen;
    logic [7:0]   drop_count;
    logic [1:0]   eth_txd;

    logic         send1;
    logic [479:0] pkt1;
    logic         busy1, tx_done1, txen1;
    logic [7:0]   drop1;
    logic [1:0]   txd1;

    always #10 eth_clk = ~eth_clk;

    eth_frame_tx #(.IPG_BYTES(IPG)) dut (
        .eth_clk(eth_clk), .rst_in(rst_in), .send_packet(send_packet), .eth_packet(eth_packet),
        .busy(busy), .tx_done(tx_done), .drop_count(drop_count), .eth_txen(eth_txen), .eth_txd(eth_txd)
    );

    eth_frame_tx #(.IPG_BYTES(1)) dut1 (
        .eth_clk(eth_clk), .rst_in(rst_in), .send_packet(send1), .eth_packet(pkt1),
        .busy(busy1), .tx_done(tx_done1), .drop_count(drop1), .eth_txen(txen1), .eth_txd(txd1)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int first_txen, txen_len, done_off, done_cnt, busy_len, txd_viol;
    bit finished;

    typedef struct {
        logic [479:0] pkt;
        int           n_str;
        bit           hold;
        int           exp_drop;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge eth_clk);
        #1;
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if ((r[0] ^ b[i]) == 1'b1) r = (r >> 1) ^ 32'hEDB8_8320;
            else r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [479:0] rand480();
        logic [479:0] p;
        for (int i = 0; i < 15; i++) p[32*i +: 32] = $urandom;
        return p;
    endfunction

    // Expected wire bytes: preamble, SFD, payload MSB byte first, then the complemented CRC low byte first.
    task automatic build_exp(input logic [479:0] p);
`ifdef ETH_TX_FCS_EN
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
`endif
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 60; i++) begin
            exp_q.push_back(p[479 - 8*i -: 8]);
`ifdef ETH_TX_FCS_EN
            c = crc_byte(c, p[479 - 8*i -: 8]);
`endif
        end
`ifdef ETH_TX_FCS_EN
        c = ~c;
        for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
`endif
    endtask

    // Sends one frame (strobe in the current cycle) and deserialises it until busy drops.
    task automatic run_frame(input logic [479:0] pkt, input int n_str, input bit hold);
        int offs[$];
        logic [7:0] cur;
        int nd;
        bit s;
        for (int i = 0; i < n_str; i++) offs.push_back(5 + i * 40 + $urandom_range(0, 30));
        got_q.delete();
        first_txen = -1; txen_len = 0; done_off = -1; done_cnt = 0;
        busy_len = 0; txd_viol = 0; finished = 1'b0; nd = 0; cur = 8'h00;
        eth_packet  = pkt;
        send_packet = 1'b1;
        tick();
        eth_packet = rand480();
        for (int c = 1; c <= BUSY_LEN + 20 && !finished; c++) begin
            if (eth_txen) begin
                txen_len++;
                if (first_txen < 0) first_txen = c;
                cur[2*nd +: 2] = eth_txd;
                nd++;
                if (nd == 4) begin
                    got_q.push_back(cur);
                    nd = 0;
                end
            end else if (eth_txd != 2'b00) begin
                txd_viol++;
            end
            if (tx_done) begin
                done_cnt++;
                done_off = c;
            end
            if (busy) busy_len++;
            else finished = 1'b1;
            s = hold;
            foreach (offs[k]) if (offs[k] == c) s = 1'b1;
            send_packet = s;
            if (!finished) tick();
        end
        send_packet = 1'b0;
    endtask

    task automatic check_frame(input string name, input logic [479:0] pkt, input int exp_drop);
        int bad;
        logic [31:0] r;
        build_exp(pkt);
        bad = 0;
        check({name, ".ended"}, 64'(finished), 64'd1);
        check({name, ".nbytes"}, 64'(got_q.size()), 64'(WIRE_BYTES));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad++;
        check({name, ".byte_errs"}, 64'(bad), 64'd0);
        check({name, ".txen_start"}, 64'(first_txen), 64'd1);
        check({name, ".txen_len"}, 64'(txen_len), 64'(TXEN_LEN));
        check({name, ".done_cycle"}, 64'(done_off), 64'(TXEN_LEN + 1));
        check({name, ".done_pulses"}, 64'(done_cnt), 64'd1);
        check({name, ".busy_len"}, 64'(busy_len), 64'(BUSY_LEN));
        check({name, ".txd_idle"}, 64'(txd_viol), 64'd0);
        check({name, ".drop_count"}, 64'(drop_count), 64'(exp_drop));
`ifdef ETH_TX_FCS_EN
        r = 32'hFFFF_FFFF;
        for (int i = 8; i < got_q.size(); i++) r = crc_byte(r, got_q[i]);
        check({name, ".crc_residue"}, 64'(r), 64'hDEBB_20E3);
`else
        r = 32'h0;
`endif
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    initial begin
        vec_t vecs[5];
        logic [479:0] arp;
        logic [479:0] p;
        int viol, exp_drop, n;
        int low, low_busy, done1_seen;
        bit prev, measuring, done1;
        logic [1:0] first_dibit;

        arp = {48'hFFFF_FFFF_FFFF, 48'h1234_5678_9ABC, 16'h0806,
               224'h0001_0800_0604_0002_1234_5678_9ABC_C0A8_0101_AABB_CCDD_EEFF_C0A8_0102, 144'h0};
        vecs[0] = '{arp,        0, 1'b0, 0};
        vecs[1] = '{rand480(),  3, 1'b0, 3};
        vecs[2] = '{480'h0,     0, 1'b0, 3};
        vecs[3] = '{~480'h0,    5, 1'b0, 8};
        vecs[4] = '{rand480(),  0, 1'b1, 255};

        rst_in = 1'b1; send_packet = 1'b0; eth_packet = 480'h0; send1 = 1'b0; pkt1 = 480'h0;
        tick(); tick(); tick();
        check("rst.txen", 64'(eth_txen), 64'd0);
        check("rst.txd", 64'(eth_txd), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.tx_done", 64'(tx_done), 64'd0);
        check("rst.drop", 64'(drop_count), 64'd0);
        rst_in = 1'b0;
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (eth_txen || eth_txd != 2'b00 || busy || tx_done || drop_count != 8'd0) viol++;
        end
        check("idle100.viol", 64'(viol), 64'd0);

        // Frame table, each request issued on the first idle cycle after the previous one.
        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].pkt, vecs[i].n_str, vecs[i].hold);
            check_frame($sformatf("vec%0d", i), vecs[i].pkt, vecs[i].exp_drop);
        end

        do_reset();
        exp_drop = 0;
        for (int i = 0; i < 4; i++) begin
            p = rand480();
            n = $urandom_range(0, 6);
            exp_drop = (exp_drop + n > 255) ? 255 : exp_drop + n;
            run_frame(p, n, 1'b0);
            check_frame($sformatf("rnd%0d", i), p, exp_drop);
        end

        // Reset arriving mid-DATA abandons the frame.
        do_reset();
        eth_packet = arp; send_packet = 1'b1;
        tick();
        eth_packet = rand480();
        for (int c = 1; c < 100; c++) begin
            send_packet = (c == 20 || c == 30);
            tick();
        end
        check("midrst.pre_drop", 64'(drop_count), 64'd2);
        check("midrst.pre_txen", 64'(eth_txen), 64'd1);
        send_packet = 1'b0; rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("midrst.txen", 64'(eth_txen), 64'd0);
        check("midrst.txd", 64'(eth_txd), 64'd0);
        check("midrst.busy", 64'(busy), 64'd0);
        check("midrst.drop", 64'(drop_count), 64'd0);
        check("midrst.tx_done", 64'(tx_done), 64'd0);
        p = rand480();
        run_frame(p, 0, 1'b0);
        check_frame("postrst", p, 0);

        // One-byte IPG with the request held high: 4 IPG cycles plus the accepting idle cycle.
        send1 = 1'b1; pkt1 = arp;
        prev = 1'b0; measuring = 1'b0; done1 = 1'b0;
        low = 0; low_busy = 0; done1_seen = 0; viol = 0; first_dibit = 2'b00;
        for (int c = 0; c < 2000 && !done1; c++) begin
            tick();
            if (!txen1 && txd1 != 2'b00) viol++;
            if (prev && !txen1) begin
                measuring = 1'b1;
                low = 0;
                low_busy = 0;
                if (tx_done1) done1_seen++;
            end
            if (measuring) begin
                if (!txen1) begin
                    low++;
                    if (busy1) low_busy++;
                end else begin
                    measuring = 1'b0;
                    done1 = 1'b1;
                    first_dibit = txd1;
                end
            end
            prev = txen1;
        end
        send1 = 1'b0;
        check("ipg1.restarted", 64'(done1), 64'd1);
        check("ipg1.ipg_cycles", 64'(low_busy), 64'd4);
        check("ipg1.gap_cycles", 64'(low), 64'd5);
        check("ipg1.first_dibit", 64'(first_dibit), 64'd1);
        check("ipg1.done_at_fall", 64'(done1_seen), 64'd1);
        check("ipg1.drop_sat", 64'(drop1), 64'd255);
        check("ipg1.txd_idle", 64'(viol), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
